// File: rtl/match_req_dispatch.sv
// Dispatch controller: accepts one request group from a job_pe, spreads its strobed
// lanes over C match request channels, then blocks until the response group is consumed.
module match_req_dispatch #(
  parameter int JOB_PE_IDX = 0,
  parameter int L          = 4,
  parameter int C          = 2,
  parameter int TAG_BITS   = 2,
  parameter int AW         = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_group_valid,
  output logic                  in_group_ready,
  input  logic [L-1:0]          in_group_strb,
  input  logic [L*AW-1:0]       in_group_addr,
  output logic                  req_group_fire,
  output logic [L-1:0]          req_group_strb,
  output logic [C-1:0]          req_valid,
  input  logic [C-1:0]          req_ready,
  output logic [C*TAG_BITS-1:0] req_tag,
  output logic [C*AW-1:0]       req_addr,
  input  logic                  resp_group_fire
);

  // Handshakes: a transfer on any valid/ready pair happens on the rising edge where
  // both are high; once valid is raised it stays high, with payload held, until ready.

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [L-1:0]          pending_q, pending_d;
  logic [L*AW-1:0]       lane_buf_q, lane_buf_d;
  logic [C-1:0]          vld_q, vld_d;
  logic [C*TAG_BITS-1:0] tag_q, tag_d;
  logic [C*AW-1:0]       addr_q, addr_d;

  logic                  accept;
  logic                  load_en;
  logic                  hit;
  logic [L-1:0]          src_strb;
  logic [L-1:0]          rem;
  logic [L*AW-1:0]       src_addr;

  assign in_group_ready = rst_n && (state_q == ST_IDLE);
  assign accept         = in_group_valid && in_group_ready;
  assign req_group_fire = accept;
  assign req_group_strb = accept ? in_group_strb : '0;

  assign req_valid = vld_q;
  assign req_tag   = tag_q;
  assign req_addr  = addr_q;

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    lane_buf_d = lane_buf_q;
    vld_d      = vld_q;
    tag_d      = tag_q;
    addr_d     = addr_q;
    hit        = 1'b0;

    // On the accept cycle the channels load straight from the input group, so the
    // first request appears one cycle after accept without waiting for the buffer.
    src_strb = (state_q == ST_IDLE) ? in_group_strb : pending_q;
    src_addr = (state_q == ST_IDLE) ? in_group_addr : lane_buf_q;
    load_en  = accept || (state_q == ST_ISSUE);
    rem      = src_strb;

    if (load_en) begin
      for (int j = 0; j < C; j++) begin
        if (!vld_q[j] || req_ready[j]) begin
          hit = 1'b0;
          for (int i = 0; i < L; i++) begin
            if (!hit && rem[i]) begin
              hit    = 1'b1;
              rem[i] = 1'b0;
              tag_d[j*TAG_BITS +: TAG_BITS] = TAG_BITS'(i);
              addr_d[j*AW +: AW]            = src_addr[i*AW +: AW];
            end
          end
          vld_d[j] = hit;
        end
      end
      pending_d = rem;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          lane_buf_d = in_group_addr;
          state_d    = (|in_group_strb) ? ST_ISSUE : ST_WAIT;
        end
      end
      ST_ISSUE: begin
        if ((rem == '0) && (vld_d == '0)) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (resp_group_fire) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      lane_buf_q <= '0;
      vld_q      <= '0;
      tag_q      <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      lane_buf_q <= lane_buf_d;
      vld_q      <= vld_d;
      tag_q      <= tag_d;
      addr_q     <= addr_d;
    end
  end

endmodule

// File: tb/tb_match_req_dispatch.sv
// Bench for match_req_dispatch: table of single-group dispatches with full ready,
// plus hand sequences for channel stall, group hold-off and mid-issue reset.
module tb_match_req_dispatch;

  localparam int L  = 4;
  localparam int C  = 2;
  localparam int TB = 2;
  localparam int AW = 16;

  logic              clk;
  logic              rst_n;
  logic              in_group_valid;
  logic              in_group_ready;
  logic [L-1:0]      in_group_strb;
  logic [L*AW-1:0]   in_group_addr;
  logic              req_group_fire;
  logic [L-1:0]      req_group_strb;
  logic [C-1:0]      req_valid;
  logic [C-1:0]      req_ready;
  logic [C*TB-1:0]   req_tag;
  logic [C*AW-1:0]   req_addr;
  logic              resp_group_fire;

  int n_cmp = 0;
  int n_err = 0;

  logic [TB+AW-1:0] exp_q[$];

  typedef struct {
    logic [L-1:0]  strb;
    logic [C-1:0]  v  [3];
    logic [TB-1:0] t0 [3];
    logic [TB-1:0] t1 [3];
  } vec_t;

  vec_t vecs [7];

  match_req_dispatch #(
    .JOB_PE_IDX (0),
    .L          (L),
    .C          (C),
    .TAG_BITS   (TB),
    .AW         (AW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_group_valid  (in_group_valid),
    .in_group_ready  (in_group_ready),
    .in_group_strb   (in_group_strb),
    .in_group_addr   (in_group_addr),
    .req_group_fire  (req_group_fire),
    .req_group_strb  (req_group_strb),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_tag         (req_tag),
    .req_addr        (req_addr),
    .resp_group_fire (resp_group_fire)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  function automatic logic [AW-1:0] lane_addr(input int g, input int i);
    return AW'(g * 4096 + (i + 1) * 16);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_group(input int g, input logic [L-1:0] s);
    in_group_valid = 1'b1;
    in_group_strb  = s;
    for (int i = 0; i < L; i++) in_group_addr[i*AW +: AW] = lane_addr(g, i);
  endtask

  task automatic push_exp(input int g, input int lane);
    exp_q.push_back({TB'(lane), lane_addr(g, lane)});
  endtask

  task automatic chk_ch(input string name, input int j, input int g, input int lane);
    chk({name, "_tag"}, 32'(req_tag[j*TB +: TB]), 32'(lane));
    chk({name, "_addr"}, 32'(req_addr[j*AW +: AW]), 32'(lane_addr(g, lane)));
  endtask

  task automatic set_vec(input int n, input logic [L-1:0] s,
                         input logic [C-1:0] v1, input logic [C-1:0] v2, input logic [C-1:0] v3,
                         input logic [TB-1:0] a1, input logic [TB-1:0] a2, input logic [TB-1:0] a3,
                         input logic [TB-1:0] b1, input logic [TB-1:0] b2, input logic [TB-1:0] b3);
    vecs[n].strb  = s;
    vecs[n].v[0]  = v1; vecs[n].v[1]  = v2; vecs[n].v[2]  = v3;
    vecs[n].t0[0] = a1; vecs[n].t0[1] = a2; vecs[n].t0[2] = a3;
    vecs[n].t1[0] = b1; vecs[n].t1[1] = b2; vecs[n].t1[2] = b3;
  endtask

  // Entered just after a rising edge with the DUT idle; leaves it idle the same way.
  task automatic run_vec(input int n);
    drive_group(n, vecs[n].strb);
    req_ready       = 2'b11;
    resp_group_fire = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_accept_ready", n), 32'(in_group_ready), 32'd1);
    chk($sformatf("v%0d_fire", n), 32'(req_group_fire), 32'd1);
    chk($sformatf("v%0d_fire_strb", n), 32'(req_group_strb), 32'(vecs[n].strb));
    for (int k = 0; k < 3; k++) begin
      if (vecs[n].v[k][0]) push_exp(n, int'(vecs[n].t0[k]));
      if (vecs[n].v[k][1]) push_exp(n, int'(vecs[n].t1[k]));
    end
    tick();
    in_group_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      resp_group_fire = (k == 2);
      @(negedge clk);
      chk($sformatf("v%0d_c%0d_valid", n, k + 1), 32'(req_valid), 32'(vecs[n].v[k]));
      chk($sformatf("v%0d_c%0d_ready", n, k + 1), 32'(in_group_ready), 32'd0);
      if (vecs[n].v[k][0]) chk_ch($sformatf("v%0d_c%0d_ch0", n, k + 1), 0, n, int'(vecs[n].t0[k]));
      if (vecs[n].v[k][1]) chk_ch($sformatf("v%0d_c%0d_ch1", n, k + 1), 1, n, int'(vecs[n].t1[k]));
      tick();
    end
    resp_group_fire = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_back_idle", n), 32'(in_group_ready), 32'd1);
    tick();
  endtask

  // scoreboard: every channel handshake must match the next expected {tag, addr}
  always @(negedge clk) begin
    if (rst_n) begin
      for (int j = 0; j < C; j++) begin
        if (req_valid[j] && req_ready[j]) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_issue ch%0d: got tag %0d addr 0x%0h, required no request",
                     j, req_tag[j*TB +: TB], req_addr[j*AW +: AW]);
          end else begin
            chk($sformatf("issue_ch%0d", j), 32'({req_tag[j*TB +: TB], req_addr[j*AW +: AW]}),
                32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    rst_n           = 1'b0;
    in_group_valid  = 1'b1;
    in_group_strb   = 4'b1111;
    in_group_addr   = '0;
    req_ready       = 2'b11;
    resp_group_fire = 1'b0;

    //            strb     valid t+1..t+3        ch0 tags        ch1 tags
    set_vec(0, 4'b1111, 2'b11, 2'b11, 2'b00, 2'd0, 2'd2, 2'd0, 2'd1, 2'd3, 2'd0);
    set_vec(1, 4'b0101, 2'b11, 2'b00, 2'b00, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0);
    set_vec(2, 4'b1000, 2'b01, 2'b00, 2'b00, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
    set_vec(3, 4'b0110, 2'b11, 2'b00, 2'b00, 2'd1, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0);
    set_vec(4, 4'b1011, 2'b11, 2'b01, 2'b00, 2'd0, 2'd3, 2'd0, 2'd1, 2'd0, 2'd0);
    set_vec(5, 4'b0000, 2'b00, 2'b00, 2'b00, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
    set_vec(6, 4'b1110, 2'b11, 2'b01, 2'b00, 2'd1, 2'd3, 2'd0, 2'd2, 2'd0, 2'd0);

    // reset state, with a group offered to prove ready/fire are held low
    @(negedge clk);
    chk("rst_ready", 32'(in_group_ready), 32'd0);
    chk("rst_fire", 32'(req_group_fire), 32'd0);
    chk("rst_fire_strb", 32'(req_group_strb), 32'd0);
    chk("rst_valid", 32'(req_valid), 32'd0);
    chk("rst_tag", 32'(req_tag), 32'd0);
    chk("rst_addr", 32'(req_addr), 32'd0);
    in_group_valid = 1'b0;
    tick();
    tick();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(in_group_ready), 32'd1);
    chk("post_rst_valid", 32'(req_valid), 32'd0);
    tick();

    for (int n = 0; n < 7; n++) run_vec(n);

    // channel 1 stalls; a second group is offered throughout ISSUE and WAIT
    drive_group(10, 4'b1111);
    req_ready = 2'b11;
    @(negedge clk);
    chk("stall_fire", 32'(req_group_fire), 32'd1);
    chk("stall_fire_strb", 32'(req_group_strb), 32'hF);
    push_exp(10, 0); push_exp(10, 2); push_exp(10, 3); push_exp(10, 1);
    tick();
    drive_group(11, 4'b0011);
    req_ready = 2'b01;
    @(negedge clk);
    chk("stall_t1_valid", 32'(req_valid), 32'h3);
    chk_ch("stall_t1_ch0", 0, 10, 0);
    chk_ch("stall_t1_ch1", 1, 10, 1);
    chk("stall_t1_holdoff", 32'(in_group_ready), 32'd0);
    chk("stall_t1_nofire", 32'(req_group_fire), 32'd0);
    tick();
    resp_group_fire = 1'b1;
    @(negedge clk);
    chk("stall_t2_valid", 32'(req_valid), 32'h3);
    chk_ch("stall_t2_ch0", 0, 10, 2);
    chk_ch("stall_t2_ch1", 1, 10, 1);
    chk("stall_t2_nofire", 32'(req_group_fire), 32'd0);
    tick();
    resp_group_fire = 1'b0;
    @(negedge clk);
    chk("stall_t3_valid", 32'(req_valid), 32'h3);
    chk_ch("stall_t3_ch0", 0, 10, 3);
    chk_ch("stall_t3_ch1", 1, 10, 1);
    tick();
    req_ready = 2'b11;
    @(negedge clk);
    chk("stall_t4_valid", 32'(req_valid), 32'h2);
    chk_ch("stall_t4_ch1", 1, 10, 1);
    chk("stall_t4_nofire", 32'(req_group_fire), 32'd0);
    tick();
    @(negedge clk);
    chk("stall_t5_valid", 32'(req_valid), 32'h0);
    chk("stall_t5_holdoff", 32'(in_group_ready), 32'd0);
    chk("stall_t5_nofire", 32'(req_group_fire), 32'd0);
    tick();
    resp_group_fire = 1'b1;
    @(negedge clk);
    chk("stall_t6_holdoff", 32'(in_group_ready), 32'd0);
    chk("stall_t6_nofire", 32'(req_group_fire), 32'd0);
    push_exp(11, 0); push_exp(11, 1);
    tick();
    resp_group_fire = 1'b0;
    @(negedge clk);
    chk("g2_ready", 32'(in_group_ready), 32'd1);
    chk("g2_fire", 32'(req_group_fire), 32'd1);
    chk("g2_fire_strb", 32'(req_group_strb), 32'h3);
    tick();
    in_group_valid = 1'b0;
    @(negedge clk);
    chk("g2_t1_valid", 32'(req_valid), 32'h3);
    chk_ch("g2_t1_ch0", 0, 11, 0);
    chk_ch("g2_t1_ch1", 1, 11, 1);
    tick();
    resp_group_fire = 1'b1;
    @(negedge clk);
    chk("g2_t2_valid", 32'(req_valid), 32'h0);
    chk("g2_t2_wait", 32'(in_group_ready), 32'd0);
    tick();
    resp_group_fire = 1'b0;
    @(negedge clk);
    chk("g2_back_idle", 32'(in_group_ready), 32'd1);
    tick();

    // asynchronous reset mid-ISSUE with lanes 2 and 3 still pending
    drive_group(12, 4'b1111);
    req_ready = 2'b00;
    @(negedge clk);
    chk("rstmid_fire", 32'(req_group_fire), 32'd1);
    tick();
    in_group_valid = 1'b0;
    @(negedge clk);
    chk("rstmid_t1_valid", 32'(req_valid), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_valid_now", 32'(req_valid), 32'h0);
    chk("rstmid_ready_now", 32'(in_group_ready), 32'd0);
    chk("rstmid_tag_now", 32'(req_tag), 32'd0);
    chk("rstmid_addr_now", 32'(req_addr), 32'd0);
    tick();
    req_ready = 2'b11;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid_rel_ready", 32'(in_group_ready), 32'd1);
    chk("rstmid_rel_valid", 32'(req_valid), 32'h0);
    tick();
    @(negedge clk);
    chk("rstmid_no_reissue", 32'(req_valid), 32'h0);
    tick();
    run_vec(0);

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
